mult4_seq_ctrl: RTL and testbench

//  Sequential 4x4 unsigned shift-and-add multiplier built around one shared 4-bit ripple-carry adder.
//  The adder has operands xi/yi, sum zi and carry-out co, with carry-in tied to 0.

---
 rtl/mult4_seq_ctrl.sv | 127 ++++++++++++
 tb/tb_mult4_seq_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mult4_seq_ctrl.sv
// Sequential 4x4 unsigned shift-and-add multiplier around one shared 4-bit ripple-carry adder.
// Optional build macro: MULT_ZERO_SKIP_EN (zero operand bypasses CALC and completes in one edge).
module mult4_seq_ctrl #(
  parameter bit DONE_HOLD = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] ma,
  input  logic [3:0] mb,
  output logic       busy,
  output logic       done,
  output logic [7:0] p
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t     state_r;
  logic [3:0] m_r;
  logic [3:0] a_r;
  logic [3:0] q_r;
  logic [1:0] cnt_r;
  logic [3:0] yi_s;
  logic [4:0] sum_s;
  logic       accept_s;
  logic       zero_skip_s;

  // 4-bit ripple-carry adder, carry-in tied low; returns {co, zi}
  function automatic logic [4:0] rca4(input logic [3:0] xi, input logic [3:0] yi);
    logic       c;
    logic [3:0] zi;
    c  = 1'b0;
    zi = 4'h0;
    for (int i = 0; i < 4; i++) begin
      zi[i] = xi[i] ^ yi[i] ^ c;
      c     = (xi[i] & yi[i]) | (c & (xi[i] ^ yi[i]));
    end
    return {c, zi};
  endfunction

  // Shared adder: accumulator plus multiplicand gated by the current multiplier LSB
  always_comb begin
    yi_s  = 4'h0;
    sum_s = 5'h00;
    if (q_r[0]) begin
      yi_s = m_r;
    end else begin
      yi_s = 4'h0;
    end
    sum_s = rca4(a_r, yi_s);
  end

  assign accept_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));

`ifdef MULT_ZERO_SKIP_EN
  assign zero_skip_s = (ma == 4'h0) || (mb == 4'h0);
`else
  assign zero_skip_s = 1'b0;
`endif

  // Control FSM, operand/accumulator registers and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      m_r     <= 4'h0;
      a_r     <= 4'h0;
      q_r     <= 4'h0;
      cnt_r   <= 2'd0;
      p       <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (accept_s) begin
      if (zero_skip_s) begin
        state_r <= ST_DONE;
        p       <= 8'h00;
        busy    <= 1'b0;
        done    <= 1'b1;
      end else begin
        state_r <= ST_CALC;
        m_r     <= ma;
        q_r     <= mb;
        a_r     <= 4'h0;
        cnt_r   <= 2'd3;
        busy    <= 1'b1;
        done    <= 1'b0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
        end
        ST_CALC: begin
          // The carry-out lands in A's MSB, so the 9th shift bit is always zero
          a_r <= sum_s[4:1];
          q_r <= {sum_s[0], q_r[3:1]};
          if (cnt_r == 2'd0) begin
            p       <= {sum_s, q_r[3:1]};
            state_r <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 2'd1;
          end
        end
        ST_DONE: begin
          if (DONE_HOLD) begin
            done <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            done    <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult4_seq_ctrl.sv
// Directed self-checking bench for mult4_seq_ctrl; one instance per DONE_HOLD setting.
module tb_mult4_seq_ctrl;

`ifdef MULT_ZERO_SKIP_EN
  localparam bit ZSKIP = 1'b1;
`else
  localparam bit ZSKIP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start0, start1;
  logic [3:0] ma0, mb0, ma1, mb1;
  logic       busy0, done0, busy1, done1;
  logic [7:0] p0, p1;
  logic [7:0] last_p;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  mult4_seq_ctrl #(.DONE_HOLD(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .ma(ma0), .mb(mb0),
    .busy(busy0), .done(done0), .p(p0)
  );

  mult4_seq_ctrl #(.DONE_HOLD(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .ma(ma1), .mb(mb1),
    .busy(busy1), .done(done1), .p(p1)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One full operation on the DONE_HOLD=0 instance, checking every cycle until done falls
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
    @(negedge clk);
    start0 = 1'b1; ma0 = a; mb0 = b;
    @(negedge clk);
    start0 = 1'b0;
    if (ZSKIP && ((a == 4'h0) || (b == 4'h0))) begin
      check_eq("skip_busy", {15'd0, busy0}, 16'd0);
      check_eq("skip_done", {15'd0, done0}, 16'd1);
      check_eq("skip_p", {8'd0, p0}, {8'd0, exp});
    end else begin
      check_eq("calc_busy", {15'd0, busy0}, 16'd1);
      check_eq("calc_done", {15'd0, done0}, 16'd0);
      repeat (3) begin
        @(negedge clk);
        check_eq("calc_busy", {15'd0, busy0}, 16'd1);
        check_eq("p_hold", {8'd0, p0}, {8'd0, last_p});
      end
      @(negedge clk);
      check_eq("end_busy", {15'd0, busy0}, 16'd0);
      check_eq("end_done", {15'd0, done0}, 16'd1);
      check_eq("end_p", {8'd0, p0}, {8'd0, exp});
    end
    @(negedge clk);
    check_eq("post_done", {15'd0, done0}, 16'd0);
    check_eq("post_p", {8'd0, p0}, {8'd0, exp});
    last_p = exp;
  endtask

  initial begin
    rst_n = 1'b0;
    start0 = 1'b0; ma0 = 4'h0; mb0 = 4'h0;
    start1 = 1'b0; ma1 = 4'h0; mb1 = 4'h0;
    last_p = 8'h00;
    #12;
    check_eq("rst_busy", {15'd0, busy0}, 16'd0);
    check_eq("rst_done", {15'd0, done0}, 16'd0);
    check_eq("rst_p", {8'd0, p0}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed products
    run_op(4'hF, 4'hF, 8'hE1);
    run_op(4'h9, 4'h6, 8'h36);
    run_op(4'h2, 4'h8, 8'h10);
    run_op(4'h0, 4'hA, 8'h00);
    run_op(4'hA, 4'h0, 8'h00);

    // start held high: back-to-back operations through DONE
    @(negedge clk);
    start0 = 1'b1; ma0 = 4'h5; mb0 = 4'h3;
    repeat (5) @(negedge clk);
    check_eq("b2b_done1", {15'd0, done0}, 16'd1);
    check_eq("b2b_p1", {8'd0, p0}, 16'h000F);
    @(negedge clk);
    check_eq("b2b_restart_done", {15'd0, done0}, 16'd0);
    check_eq("b2b_restart_busy", {15'd0, busy0}, 16'd1);
    start0 = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("b2b_done2", {15'd0, done0}, 16'd1);
    check_eq("b2b_p2", {8'd0, p0}, 16'h000F);
    @(negedge clk);
    last_p = 8'h0F;

    // start and operand changes during CALC are ignored
    @(negedge clk);
    start0 = 1'b1; ma0 = 4'h9; mb0 = 4'h6;
    @(negedge clk);
    start0 = 1'b0; ma0 = 4'h3;
    @(negedge clk);
    start0 = 1'b1; ma0 = 4'h1; mb0 = 4'h1;
    repeat (2) @(negedge clk);
    start0 = 1'b0;
    check_eq("ign_busy", {15'd0, busy0}, 16'd1);
    @(negedge clk);
    check_eq("ign_done", {15'd0, done0}, 16'd1);
    check_eq("ign_p", {8'd0, p0}, 16'h0036);
    @(negedge clk);
    check_eq("ign_post_done", {15'd0, done0}, 16'd0);
    check_eq("ign_post_busy", {15'd0, busy0}, 16'd0);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    start0 = 1'b1; ma0 = 4'h7; mb0 = 4'h3;
    @(negedge clk);
    start0 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", {15'd0, busy0}, 16'd0);
    check_eq("arst_done", {15'd0, done0}, 16'd0);
    check_eq("arst_p", {8'd0, p0}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    last_p = 8'h00;
    @(negedge clk);
    check_eq("arst_no_done", {15'd0, done0}, 16'd0);
    run_op(4'h7, 4'h3, 8'h15);

    // DONE_HOLD=1 instance: result and done held until the next start
    @(negedge clk);
    start1 = 1'b1; ma1 = 4'h3; mb1 = 4'h5;
    @(negedge clk);
    start1 = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("hold_done", {15'd0, done1}, 16'd1);
    check_eq("hold_p", {8'd0, p1}, 16'h000F);
    repeat (10) @(negedge clk);
    check_eq("hold10_done", {15'd0, done1}, 16'd1);
    check_eq("hold10_p", {8'd0, p1}, 16'h000F);
    check_eq("hold10_busy", {15'd0, busy1}, 16'd0);
    start1 = 1'b1; ma1 = 4'h7; mb1 = 4'h7;
    @(negedge clk);
    start1 = 1'b0;
    check_eq("hold_restart_done", {15'd0, done1}, 16'd0);
    check_eq("hold_restart_busy", {15'd0, busy1}, 16'd1);
    check_eq("hold_restart_p", {8'd0, p1}, 16'h000F);
    repeat (4) @(negedge clk);
    check_eq("hold2_done", {15'd0, done1}, 16'd1);
    check_eq("hold2_p", {8'd0, p1}, 16'h0031);
    repeat (3) @(negedge clk);
    check_eq("hold2_keep", {15'd0, done1}, 16'd1);

    // Exhaustive sweep against the arithmetic model
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(4'(a), 4'(b), 8'(a * b));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
